cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmitting end of the Common Data Bus. Functional units hand completed results (ROB tag + value) to this block; the reservation stations and ROB receive them.
- Each FU source has its own small result queue. One queued result per cycle is selected round-robin and driven onto a registered CDB.
- Sits between the FU outputs and the CDB input of the reservation station module and ROB.
- On a branch mispredict, all queues and the bus are flushed.

Parameters:
- NUM_SRC, 4, number of FU result sources (one per reservation station / FU).
- DEPTH, 2, entries per source queue; power of two, at least 2.
- TAG_W, 3, ROB tag width (8-entry ROB).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mispredicted  input  1  flush request from the new-PC logic
- fu_valid  input  NUM_SRC  result valid, one bit per source
- fu_tag  input  NUM_SRC*TAG_W  ROB tag per source; source i occupies bits [i*TAG_W +: TAG_W]
- fu_value  input  NUM_SRC*32  result value per source, packed the same way as fu_tag
- fu_ready  output  NUM_SRC  source queue can accept a result
- CDB  output  CDB_packet_t  fields valid (1), tag (TAG_W), value (32)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. All state updates occur on the rising edge of clk.
- Reset values:
  - All queues empty; occupancy counters and read/write pointers are 0.
  - Round-robin pointer rr_ptr = 0.
  - CDB.valid = 0, CDB.tag = 0, CDB.value = 0.
  - fu_ready = all ones from the first cycle after reset.
- Ready:
  - fu_ready[i] = (count[i] != DEPTH).
  - It is a function of registered state only and never depends on fu_valid.
  - A full queue that is dequeued in the same cycle still shows ready = 0 (no same-cycle pass-through).
- Enqueue:
  - Occurs when fu_valid[i] & fu_ready[i] at the clock edge.
  - The {tag, value} pair is written at wr_ptr[i]; wr_ptr increments mod DEPTH.
  - If fu_valid[i] is high while ready is low, the result is not taken. The FU must hold its result.
- Arbitration (combinational on current state):
  - Scan sources starting at rr_ptr, i.e. rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - The first source with count != 0 is granted.
  - On a grant, the head entry is dequeued, rd_ptr increments mod DEPTH, and rr_ptr becomes grant+1 mod NUM_SRC.
  - With no grant, rr_ptr is unchanged.
- Queue update: enqueue and dequeue on the same queue in one cycle is legal; count is then unchanged.
- CDB register:
  - On a grant, next CDB = {1, head tag, head value}.
  - Without a grant, next CDB = {0, 0, 0}.
  - At most one broadcast per cycle.
- Latency: a result accepted at edge N appears on CDB at the earliest after edge N+1. Maximum wait in a queue is bounded by NUM_SRC*DEPTH cycles.
- Mispredict:
  - When mispredicted = 1 at an edge, all counts and pointers clear, rr_ptr = 0, and next CDB.valid = 0.
  - No enqueue is performed that cycle; FU inputs presented that cycle are dropped.
- Precedence: reset > mispredicted > normal operation.
- Reset mid-operation discards all queued results. Nothing is broadcast in the cycle following reset.

Decomposition:
- Shared package (structs.svh):
  - CDB_packet_t with fields valid, tag[TAG_W-1:0], value[31:0].
  - Constant ROB_TAG_W = 3.
  - Constant NUM_FU = 4.
- Sub-module cdb_src_fifo:
  - Parameterised by DEPTH and TAG_W.
  - Ports: clk, reset, flush, enq, enq_tag, enq_value, deq, head_tag, head_value, empty, full.
  - Instantiated NUM_SRC times.
- Top-level logic: the round-robin arbiter and the CDB register.

Test Plan:
- Reset: drive reset for 2 cycles with fu_valid = 4'b1111 → CDB.valid = 0 throughout and one cycle after release, fu_ready = 4'b1111, no result broadcast.
- Single result: source 2 presents tag 3'd5, value 32'hDEADBEEF for one cycle → CDB = {1, 5, DEADBEEF} exactly one cycle after acceptance, then CDB.valid = 0.
- Round-robin: all four sources enqueue in the same cycle with tags 0, 1, 2, 3 → broadcast order is tags 0, 1, 2, 3 on consecutive cycles. Then enqueue sources 0 and 3 together → source 0 wins next, not 3, because rr_ptr = 0 after the grant to source 3 wraps.
- Full/backpressure: hold source 1 valid with tags 1, 2, 3 while sources 0 and 3 stay continuously loaded → fu_ready[1] = 0 after 2 accepts. Tag 3 is held by the FU and accepted only after the first source-1 broadcast. Source-1 tags appear on CDB in order 1, 2, 3 with no loss or duplication.
- Mispredict flush: fill all queues (8 entries), then assert mispredicted for 1 cycle while source 0 presents tag 7 → CDB.valid = 0 the next cycle and stays 0. Tag 7 never broadcasts, fu_ready = 4'b1111, and rr_ptr restarts at 0.
- Simultaneous enqueue and dequeue: source 0 streams one result per cycle for 10 cycles with no other sources active → CDB.valid = 1 for 10 consecutive cycles, tags in order, and count[0] never exceeds 1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and constants.
// CDB_packet_t is the broadcast bundle seen by the RS and ROB.
package cdb_arbiter_pkg;

  localparam int ROB_TAG_W = 3;
  localparam int NUM_FU    = 4;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          value;
  } CDB_packet_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue for the CDB arbiter.
// Ports: clk, reset, flush, enq/enq_tag/enq_value in, deq in, head_tag/head_value, empty, full out.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq,
  input  logic [TAG_W-1:0] enq_tag,
  input  logic [31:0]      enq_value,
  input  logic             deq,
  output logic [TAG_W-1:0] head_tag,
  output logic [31:0]      head_value,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [31:0]      val_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_enq;
  logic             do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;

  assign head_tag   = tag_mem[rd_ptr];
  assign head_value = val_mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      tag_mem[wr_ptr] <= enq_tag;
      val_mem[wr_ptr] <= enq_value;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-FU result queues.
// Ports: clk, reset, mispredicted, fu_valid/fu_tag/fu_value in, fu_ready out, CDB out.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_FU,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = ROB_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mispredicted,
  input  logic [NUM_SRC-1:0]       fu_valid,
  input  logic [NUM_SRC*TAG_W-1:0] fu_tag,
  input  logic [NUM_SRC*32-1:0]    fu_value,
  output logic [NUM_SRC-1:0]       fu_ready,
  output CDB_packet_t              CDB
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [TAG_W-1:0]   head_tag   [NUM_SRC];
  logic [31:0]        head_value [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] enq;
  logic [NUM_SRC-1:0] deq;
  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      gnt_idx;
  logic [SW-1:0]      rr_next;
  logic               gnt_any;

  // Ready looks only at registered occupancy.
  assign fu_ready = ~full;
  assign enq = fu_valid & fu_ready
             & {NUM_SRC{~mispredicted}};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      cdb_src_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
      ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (mispredicted),
        .enq        (enq[g]),
        .enq_tag    (fu_tag[g*TAG_W +: TAG_W]),
        .enq_value  (fu_value[g*32 +: 32]),
        .deq        (deq[g]),
        .head_tag   (head_tag[g]),
        .head_value (head_value[g]),
        .empty      (empty[g]),
        .full       (full[g])
      );
    end
  endgenerate

  // First non-empty source at or after rr_ptr.
  always_comb begin : arb
    int s;
    s       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = (int'(rr_ptr) + k) % NUM_SRC;
      if (!gnt_any && !empty[SW'(s)]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(s);
      end
    end
  end

  assign rr_next =
    SW'((int'(gnt_idx) + 1) % NUM_SRC);

  assign deq = gnt_any
    ? (NUM_SRC'(1) << gnt_idx)
    : '0;

  always_ff @(posedge clk) begin
    if (reset || mispredicted) begin
      CDB    <= '0;
      rr_ptr <= '0;
    end else if (gnt_any) begin
      CDB.valid <= 1'b1;
      CDB.tag   <= head_tag[gnt_idx];
      CDB.value <= head_value[gnt_idx];
      rr_ptr    <= rr_next;
    end else begin
      CDB <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter.
// A queue-level model predicts each CDB cycle and fu_ready.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int TW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            mispredicted;
  logic [N-1:0]    fu_valid;
  logic [N*TW-1:0] fu_tag;
  logic [N*32-1:0] fu_value;
  logic [N-1:0]    fu_ready;
  CDB_packet_t     CDB;

  cdb_arbiter #(
    .NUM_SRC (N),
    .DEPTH   (D),
    .TAG_W   (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mispredicted (mispredicted),
    .fu_valid     (fu_valid),
    .fu_tag       (fu_tag),
    .fu_value     (fu_value),
    .fu_ready     (fu_ready),
    .CDB          (CDB)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [34:0] mq [N][$];
  int          rr_m = 0;
  CDB_packet_t exp_q [$];
  logic [N-1:0] acc;

  logic        pend_v [N];
  logic [2:0]  pend_t [N];
  logic [31:0] pend_d [N];

  // Reference model: one FIFO per source, round-robin pick.
  always @(posedge clk) begin : model
    CDB_packet_t e;
    logic [N-1:0] rdy;
    logic hit;
    int s;
    e   = '0;
    acc = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      rdy[i] = (mq[i].size() < D);
    if (reset || mispredicted) begin
      for (int i = 0; i < N; i++)
        mq[i].delete();
      rr_m = 0;
      acc  = '1;
    end else begin
      for (int k = 0; k < N; k++) begin
        s = (rr_m + k) % N;
        if (!hit && mq[s].size() > 0) begin
          e    = {1'b1, mq[s].pop_front()};
          hit  = 1'b1;
          rr_m = (s + 1) % N;
        end
      end
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && rdy[i]) begin
          mq[i].push_back({fu_tag[i*TW +: TW],
                           fu_value[i*32 +: 32]});
          acc[i] = 1'b1;
        end
    end
    exp_q.push_back(e);
  end

  // Monitor: compare bus and ready away from the edge.
  always @(negedge clk) begin : mon
    CDB_packet_t e;
    logic [N-1:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (CDB !== e) begin
        n_bad++;
        $display("FAIL cdb t=%0t got %0b/%0d/%h exp %0b/%0d/%h",
          $time, CDB.valid, CDB.tag, CDB.value,
          e.valid, e.tag, e.value);
      end
      for (int i = 0; i < N; i++)
        r[i] = (mq[i].size() != D);
      n_vec++;
      if (fu_ready !== r) begin
        n_bad++;
        $display("FAIL ready t=%0t got %b exp %b",
          $time, fu_ready, r);
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fu_valid[i]           = pend_v[i];
      fu_tag[i*TW +: TW]    = pend_t[i];
      fu_value[i*32 +: 32]  = pend_d[i];
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) pend_v[i] = 1'b0;
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic offer(int i, logic [2:0] t,
                       logic [31:0] d);
    pend_v[i] = 1'b1;
    pend_t[i] = t;
    pend_d[i] = d;
  endtask

  function automatic logic any_pend();
    logic a;
    a = 1'b0;
    for (int i = 0; i < N; i++)
      a = a | pend_v[i];
    return a;
  endfunction

  task automatic drain(int lim);
    int c;
    c = 0;
    while (any_pend() && c < lim) begin
      tick();
      c++;
    end
    n_vec++;
    if (any_pend()) begin
      n_bad++;
      $display("FAIL drain t=%0t got pending exp none",
        $time);
    end
  endtask

  task automatic flush_pulse();
    mispredicted = 1'b1;
    tick();
    mispredicted = 1'b0;
  endtask

  int nxt1;

  initial begin
    reset        = 1'b1;
    mispredicted = 1'b0;
    for (int i = 0; i < N; i++)
      offer(i, 3'(i), 32'h100 + i);
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    idle(3);

    offer(2, 3'd5, 32'hDEADBEEF);
    drain(10);
    idle(4);

    flush_pulse();
    for (int i = 0; i < N; i++)
      offer(i, 3'(i), 32'hA000 + i);
    drain(10);
    idle(6);
    offer(0, 3'd6, 32'hB0);
    offer(3, 3'd7, 32'hB3);
    drain(10);
    idle(4);

    nxt1 = 1;
    for (int c = 0; c < 40; c++) begin
      if (!pend_v[0]) offer(0, 3'd4, $urandom);
      if (!pend_v[3]) offer(3, 3'd6, $urandom);
      if (!pend_v[1] && nxt1 <= 3) begin
        offer(1, 3'(nxt1), 32'hC0 + nxt1);
        nxt1++;
      end
      tick();
    end
    drain(20);
    idle(10);

    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i]) offer(i, 3'(i), $urandom);
      tick();
    end
    offer(0, 3'd7, 32'h77777777);
    flush_pulse();
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    idle(6);

    for (int c = 0; c < 10; c++) begin
      offer(0, 3'(c), 32'hD00 + c);
      tick();
    end
    idle(4);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(2) == 0)
          offer(i, 3'($urandom), $urandom);
      mispredicted = ($urandom_range(49) == 0);
      reset        = ($urandom_range(199) == 0);
      tick();
      mispredicted = 1'b0;
      reset        = 1'b0;
    end
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
